bus_target_fifo: RTL and testbench



---
 rtl/bus_target_fifo_if.sv | 44 ++++
 rtl/bus_target_fifo.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_bus_target_fifo.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_target_fifo_if.sv
// -----------------------------------------------------------------------------
// bus_target_fifo_if
//
// Control half of the shared 32-bit CPU bus between one initiator and the
// bus_target_fifo responder.
//
// Signals:
//   cs    - chip select, driven by the initiator
//   rd    - read strobe, driven by the initiator
//   wr    - write strobe, driven by the initiator
//   addr  - 12-bit byte address, driven by the initiator
//   ready - one-cycle acknowledge, driven by the target
//
// The bidirectional data lines are a resolved net shared by every agent on
// the bus, so they stay a plain inout wire on the target rather than a
// variable inside this interface.
//
// Modports:
//   master - initiator view (drives cs/rd/wr/addr, samples ready)
//   slave  - target view (samples cs/rd/wr/addr, drives ready)
// -----------------------------------------------------------------------------
interface bus_target_fifo_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic        ready;

    modport master (
        output cs,
        output rd,
        output wr,
        output addr,
        input  ready
    );

    modport slave (
        input  cs,
        input  rd,
        input  wr,
        input  addr,
        output ready
    );
endinterface

// File: rtl/bus_target_fifo.sv
// -----------------------------------------------------------------------------
// bus_target_fifo
//
// Memory-mapped responder on the shared 32-bit CPU bus. Decodes a 16-byte
// window (addr[11:4] == BASE), inserts WAIT_CYCLES wait states, then gives a
// one-cycle ready. Behind the window sit an 8 x 32-bit mailbox FIFO and the
// STATUS, CTRL and ID registers:
//
//   addr[3:2] = 0  DATA    write pushes, read pops and returns the head
//   addr[3:2] = 1  STATUS  {23'b0, err_proto, err_udf, err_ovf, full, empty,
//                           count[3:0]}
//   addr[3:2] = 2  CTRL    bit0 irq_en (R/W), bit1 flush (W1, reads 0),
//                          bit2 err_clr (W1, reads 0)
//   addr[3:2] = 3  ID      reads ID_VALUE, writes acknowledged and dropped
//
// Parameters:
//   BASE        - match value for addr[11:4]
//   WAIT_CYCLES - wait states before ready (0-15)
//   ID_VALUE    - value returned by the ID register
//
// Ports:
//   clk    - single clock, all logic on the rising edge
//   reset  - synchronous, active-high
//   bus    - slave modport carrying cs, rd, wr, addr and ready
//   data   - shared 32-bit data bus; driven only during ACK of a read
//   irq    - registered mailbox-not-empty interrupt (BUS_TARGET_IRQ_EN only)
//
// Build option:
//   BUS_TARGET_IRQ_EN - when defined, adds the irq port and makes CTRL bit0
//                       a real irq_en bit; when undefined, irq is absent and
//                       CTRL bit0 reads 0 and ignores writes.
//
// Push, pop and CTRL side effects all commit on the edge that ends ACK, so a
// transaction observes (and a STATUS read returns) the pre-commit state.
// -----------------------------------------------------------------------------
module bus_target_fifo #(
    parameter logic [7:0]  BASE        = 8'h00,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h0A5E_0001
) (
    input  logic             clk,
    input  logic             reset,
    bus_target_fifo_if.slave bus,
    inout  wire  [31:0]      data
`ifdef BUS_TARGET_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    // WAIT is skipped entirely for zero wait states; otherwise the counter
    // starts at WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 32'd0);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 32'd1);

    // ---------------- transaction registers ----------------
    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        is_wr_r;
    logic [1:0]  sel_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        drive_r;
    logic [31:0] rdata_r;

    // ---------------- FIFO and CSR state ----------------
    logic [31:0] mem_r [0:7];
    logic [2:0]  wr_ptr_r;
    logic [2:0]  rd_ptr_r;
    logic [3:0]  count_r;
    logic        err_proto_r;
    logic        err_udf_r;
    logic        err_ovf_r;
`ifdef BUS_TARGET_IRQ_EN
    logic        irq_en_r;
    logic        irq_r;
`endif

    // ---------------- combinational decode ----------------
    logic        req_s;
    logic        proto_s;
    logic        full_s;
    logic        empty_s;
    logic [1:0]  rd_sel_s;
    logic [31:0] rd_word_s;
    logic [31:0] ctrl_rd_s;
    logic        commit_s;
    logic        data_op_s;
    logic        push_s;
    logic        pop_s;
    logic        ovf_s;
    logic        udf_s;
    logic        ctrl_wr_s;
    logic        flush_s;
    logic        clr_s;
    logic        unused_addr_s;

    // Byte-lane bits are don't-care for word registers.
    assign unused_addr_s = ^bus.addr[1:0];

    function automatic logic [31:0] pack_status(
        input logic       ep,
        input logic       eu,
        input logic       eo,
        input logic       f,
        input logic       e,
        input logic [3:0] c
    );
        return {23'd0, ep, eu, eo, f, e, c};
    endfunction

    assign full_s  = (count_r == 4'd8);
    assign empty_s = (count_r == 4'd0);

`ifdef BUS_TARGET_IRQ_EN
    assign ctrl_rd_s = {31'd0, irq_en_r};
`else
    assign ctrl_rd_s = 32'd0;
`endif

    // Request / protocol-error decode; only meaningful while IDLE.
    always_comb begin
        req_s   = 1'b0;
        proto_s = 1'b0;
        if ((state_r == ST_IDLE) && bus.cs) begin
            req_s   = (bus.rd ^ bus.wr) && (bus.addr[11:4] == BASE);
            proto_s = bus.rd && bus.wr;
        end else begin
            req_s   = 1'b0;
            proto_s = 1'b0;
        end
    end

    // Read mux: in IDLE the live address feeds the zero-wait path, later the latched one.
    always_comb begin
        rd_word_s = 32'd0;
        if (state_r == ST_IDLE) begin
            rd_sel_s = bus.addr[3:2];
        end else begin
            rd_sel_s = sel_r;
        end
        case (rd_sel_s)
            REG_DATA:   rd_word_s = empty_s ? 32'd0 : mem_r[rd_ptr_r];
            REG_STATUS: rd_word_s = pack_status(err_proto_r, err_udf_r, err_ovf_r,
                                                full_s, empty_s, count_r);
            REG_CTRL:   rd_word_s = ctrl_rd_s;
            REG_ID:     rd_word_s = ID_VALUE;
            default:    rd_word_s = 32'd0;
        endcase
    end

    // Side-effect strobes, all qualified by the ACK cycle.
    always_comb begin
        commit_s  = (state_r == ST_ACK);
        data_op_s = commit_s && (sel_r == REG_DATA);
        push_s    = data_op_s && is_wr_r && !full_s;
        ovf_s     = data_op_s && is_wr_r && full_s;
        pop_s     = data_op_s && !is_wr_r && !empty_s;
        udf_s     = data_op_s && !is_wr_r && empty_s;
        ctrl_wr_s = commit_s && is_wr_r && (sel_r == REG_CTRL);
        flush_s   = ctrl_wr_s && wdata_r[1];
        clr_s     = ctrl_wr_s && wdata_r[2];
    end

    // Bus FSM: latches the request, counts wait states, registers ready, drive enable and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            is_wr_r <= 1'b0;
            sel_r   <= 2'd0;
            wdata_r <= 32'd0;
            ready_r <= 1'b0;
            drive_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    drive_r <= 1'b0;
                    if (req_s) begin
                        is_wr_r <= bus.wr;
                        sel_r   <= bus.addr[3:2];
                        wdata_r <= data;
                        if (NO_WAIT) begin
                            state_r <= ST_ACK;
                            ready_r <= 1'b1;
                            drive_r <= bus.rd;
                            rdata_r <= bus.rd ? rd_word_s : 32'd0;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_ACK;
                        ready_r <= 1'b1;
                        drive_r <= !is_wr_r;
                        rdata_r <= is_wr_r ? 32'd0 : rd_word_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    // Unconditional: the initiator drops cs after ready.
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    drive_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    drive_r <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; flush wins over a simultaneous push/pop (cannot coincide anyway).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else if (flush_s) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 3'd1;
            count_r  <= count_r + 4'd1;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 3'd1;
            count_r  <= count_r - 4'd1;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_r;
        end
    end

    // Sticky error flags, cleared only by reset or a CTRL err_clr write.
    always_ff @(posedge clk) begin
        if (reset || clr_s) begin
            err_proto_r <= 1'b0;
            err_udf_r   <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            if (proto_s) begin
                err_proto_r <= 1'b1;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
            if (udf_s) begin
                err_udf_r <= 1'b1;
            end
        end
    end

`ifdef BUS_TARGET_IRQ_EN
    // CTRL irq_en bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_en_r <= wdata_r[0];
        end
    end

    // Interrupt follows the registered FIFO state one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r & ~empty_s;
        end
    end

    assign irq = irq_r;
`endif

    assign bus.ready = ready_r;
    assign data      = drive_r ? rdata_r : {32{1'bz}};

endmodule

// File: tb/tb_bus_target_fifo.sv
// -----------------------------------------------------------------------------
// tb_bus_target_fifo
//
// Directed bench for bus_target_fifo (BASE=0, WAIT_CYCLES=2). The data bus
// has a pull-up on every bit, so a released bus reads 32'hFFFF_FFFF.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_bus_target_fifo;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_wdata = 32'd0;
    wire  [31:0] data;
`ifdef BUS_TARGET_IRQ_EN
    logic        irq;
`endif

    bus_target_fifo_if bus ();

    int          checks   = 0;
    int          failures = 0;
    int          hiz_bad  = 0;
    logic        post_ready;
    logic [31:0] post_data;

    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    assign data = tb_oe ? tb_wdata : {32{1'bz}};

    for (genvar gi = 0; gi < 32; gi++) begin : g_pu
        pullup pu (data[gi]);
    end

    always #5 clk = ~clk;

    bus_target_fifo #(
        .BASE        (8'h00),
        .WAIT_CYCLES (2),
        .ID_VALUE    (32'h0A5E_0001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data)
`ifdef BUS_TARGET_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    // One complete initiator transaction. Returns the sampled read data, the
    // number of rising edges from request to ready, and whether ready came.
    // Afterwards it steps past the ACK cycle and records ready/data there.
    task automatic do_xfer(input logic is_wr, input logic [11:0] a, input logic [31:0] wd,
                           output logic [31:0] rdv, output int lat, output logic got);
        @(negedge clk);
        bus.cs   = 1'b1;
        bus.rd   = !is_wr;
        bus.wr   = is_wr;
        bus.addr = a;
        tb_wdata = wd;
        tb_oe    = is_wr;
        lat      = 0;
        got      = 1'b0;
        rdv      = 32'd0;
        hiz_bad  = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.ready) begin
                got = 1'b1;
                rdv = data;
            end else if (!is_wr && data !== RELEASED) begin
                hiz_bad++;
            end
        end
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        tb_oe  = 1'b0;
        @(posedge clk); #1;
        post_ready = bus.ready;
        post_data  = data;
    endtask

    task automatic test_reset();
        logic [31:0] rv;
        int          lat;
        logic        got;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++;
        if (data !== RELEASED) begin failures++; $display("FAIL reset_bus got=%h exp=%h", data, RELEASED); end
`ifdef BUS_TARGET_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
        @(negedge clk);
        reset = 1'b0;
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL reset_status got=%h exp=00000010", rv); end
    endtask

    task automatic test_id_read();
        logic [31:0] rv;
        int          lat;
        logic        got;
        do_xfer(1'b0, 12'h00C, 32'd0, rv, lat, got);
        checks++;
        if (got !== 1'b1 || lat !== 3) begin failures++; $display("FAIL id_latency got=%0d(ready=%b) exp=3", lat, got); end
        checks++;
        if (rv !== 32'h0A5E_0001) begin failures++; $display("FAIL id_data got=%h exp=0a5e0001", rv); end
        checks++;
        if (hiz_bad !== 0) begin failures++; $display("FAIL id_bus_wait got=%0d driven cycles exp=0", hiz_bad); end
        checks++;
        if (post_ready !== 1'b0 || post_data !== RELEASED) begin
            failures++; $display("FAIL id_after_ack got=ready %b data %h exp=ready 0 data %h", post_ready, post_data, RELEASED);
        end
        // Writes to ID are acknowledged and leave the value untouched.
        do_xfer(1'b1, 12'h00C, 32'h1234_5678, rv, lat, got);
        checks++;
        if (got !== 1'b1 || lat !== 3) begin failures++; $display("FAIL id_write_ack got=%0d(ready=%b) exp=3", lat, got); end
        do_xfer(1'b0, 12'h00C, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0A5E_0001) begin failures++; $display("FAIL id_after_write got=%h exp=0a5e0001", rv); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] rv;
        int          lat;
        logic        got;
        logic [31:0] vals [3];
        vals = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
        for (int i = 0; i < 3; i++) begin
            do_xfer(1'b1, 12'h000, vals[i], rv, lat, got);
            checks++;
            if (got !== 1'b1 || lat !== 3) begin failures++; $display("FAIL push_ack[%0d] got=%0d(ready=%b) exp=3", i, lat, got); end
        end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0003) begin failures++; $display("FAIL status_3 got=%h exp=00000003", rv); end
        for (int i = 0; i < 3; i++) begin
            do_xfer(1'b0, 12'h000, 32'd0, rv, lat, got);
            checks++;
            if (rv !== vals[i]) begin failures++; $display("FAIL pop[%0d] got=%h exp=%h", i, rv, vals[i]); end
        end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL status_drained got=%h exp=00000010", rv); end
    endtask

    task automatic test_overflow();
        logic [31:0] rv;
        int          lat;
        logic        got;
        int          acks;
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            do_xfer(1'b1, 12'h000, 32'h0000_0100 + 32'(i), rv, lat, got);
            if (got) acks++;
        end
        checks++;
        if (acks !== 9) begin failures++; $display("FAIL ovf_acks got=%0d exp=9", acks); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0068) begin failures++; $display("FAIL status_full got=%h exp=00000068", rv); end
        // Pointers wrap here (they started at 3 after the previous test).
        for (int i = 0; i < 8; i++) begin
            do_xfer(1'b0, 12'h000, 32'd0, rv, lat, got);
            checks++;
            if (rv !== 32'h0000_0100 + 32'(i)) begin
                failures++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, rv, 32'h0000_0100 + 32'(i));
            end
        end
        do_xfer(1'b0, 12'h000, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'd0) begin failures++; $display("FAIL ovf_lost_word got=%h exp=00000000", rv); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_00D0) begin failures++; $display("FAIL status_ovf_udf got=%h exp=000000d0", rv); end
        do_xfer(1'b1, 12'h008, 32'h0000_0004, rv, lat, got);
    endtask

    task automatic test_underflow();
        logic [31:0] rv;
        int          lat;
        logic        got;
        do_xfer(1'b0, 12'h000, 32'd0, rv, lat, got);
        checks++;
        if (got !== 1'b1 || rv !== 32'd0) begin failures++; $display("FAIL udf_data got=%h(ready=%b) exp=00000000", rv, got); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0090) begin failures++; $display("FAIL status_udf got=%h exp=00000090", rv); end
        do_xfer(1'b1, 12'h008, 32'h0000_0004, rv, lat, got);
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL status_err_clr got=%h exp=00000010", rv); end
    endtask

    task automatic test_protocol();
        logic [31:0] rv;
        int          lat;
        logic        got;
        int          rdy;
        int          bus_bad;
        @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 12'h000;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.ready) rdy++;
        end
        bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
        checks++;
        if (rdy !== 0) begin failures++; $display("FAIL proto_no_ready got=%0d pulses exp=0", rdy); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0110) begin failures++; $display("FAIL status_proto got=%h exp=00000110", rv); end
        do_xfer(1'b1, 12'h008, 32'h0000_0004, rv, lat, got);
        // Outside the window: silently ignored.
        @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 12'h100;
        rdy = 0;
        bus_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.ready) rdy++;
            if (data !== RELEASED) bus_bad++;
        end
        bus.cs = 1'b0; bus.rd = 1'b0;
        checks++;
        if (rdy !== 0 || bus_bad !== 0) begin
            failures++; $display("FAIL miss_ignored got=%0d ready, %0d driven exp=0,0", rdy, bus_bad);
        end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL status_after_miss got=%h exp=00000010", rv); end
    endtask

    task automatic test_ctrl_flush();
        logic [31:0] rv;
        int          lat;
        logic        got;
        logic [31:0] ctrl_exp;
`ifdef BUS_TARGET_IRQ_EN
        ctrl_exp = 32'h0000_0001;
`else
        ctrl_exp = 32'h0000_0000;
`endif
        do_xfer(1'b1, 12'h000, 32'hAAAA_0001, rv, lat, got);
        do_xfer(1'b1, 12'h000, 32'hAAAA_0002, rv, lat, got);
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0002) begin failures++; $display("FAIL status_two got=%h exp=00000002", rv); end
        do_xfer(1'b1, 12'h008, 32'h0000_0003, rv, lat, got);
        do_xfer(1'b0, 12'h008, 32'd0, rv, lat, got);
        checks++;
        if (rv !== ctrl_exp) begin failures++; $display("FAIL ctrl_read got=%h exp=%h", rv, ctrl_exp); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL status_flushed got=%h exp=00000010", rv); end
        do_xfer(1'b1, 12'h008, 32'h0000_0000, rv, lat, got);
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 12'h00C;
        n1 = 0;
        do begin
            @(posedge clk); #1;
            n1++;
        end while (!bus.ready && n1 < 20);
        n2 = 0;
        do begin
            @(posedge clk); #1;
            n2++;
        end while (!bus.ready && n2 < 20);
        checks++;
        if (n1 !== 3 || n2 !== 4) begin failures++; $display("FAIL b2b_period got=%0d,%0d exp=3,4", n1, n2); end
        checks++;
        if (data !== 32'h0A5E_0001) begin failures++; $display("FAIL b2b_data got=%h exp=0a5e0001", data); end
        bus.cs = 1'b0; bus.rd = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rv;
        int          lat;
        logic        got;
        int          rdy;
`ifdef BUS_TARGET_IRQ_EN
        do_xfer(1'b1, 12'h008, 32'h0000_0001, rv, lat, got);
`endif
        do_xfer(1'b1, 12'h000, 32'h0000_00AB, rv, lat, got);
`ifdef BUS_TARGET_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
`endif
        @(negedge clk);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = 12'h000; tb_wdata = 32'h0000_00CD; tb_oe = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        bus.cs = 1'b0; bus.wr = 1'b0; tb_oe = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.ready !== 1'b0 || data !== RELEASED) begin
            failures++; $display("FAIL midreset_outputs got=ready %b data %h exp=ready 0 data %h", bus.ready, data, RELEASED);
        end
`ifdef BUS_TARGET_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
`endif
        @(negedge clk);
        reset = 1'b0;
        rdy = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.ready) rdy++;
        end
        checks++;
        if (rdy !== 0) begin failures++; $display("FAIL midreset_ready got=%0d pulses exp=0", rdy); end
        do_xfer(1'b0, 12'h004, 32'd0, rv, lat, got);
        checks++;
        if (rv !== 32'h0000_0010) begin failures++; $display("FAIL midreset_status got=%h exp=00000010", rv); end
    endtask

    initial begin
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = 12'h000;
        test_reset();
        test_id_read();
        test_fifo_order();
        test_overflow();
        test_underflow();
        test_protocol();
        test_ctrl_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
